branch_resolve_queue: RTL and testbench

//  Stage directly downstream of the tournament predictor. Holds each issued

---
 rtl/branch_resolve_queue.sv | 122 ++++++++++++
 tb/tb_branch_resolve_queue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// In-order queue of issued branch predictions, resolved against actual outcomes.
// Emits predictor training, misprediction redirect and hit/miss statistics.
module branch_resolve_queue #(
  parameter int n     = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pred_valid,
  input  logic [n-1:0]             PC,
  input  logic                     prediction,
  input  logic [n-1:0]             nex_PC,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [n-1:0]             res_target,
  output logic                     pred_ready,
  output logic                     fix_valid,
  output logic                     fix_result,
  output logic [n-1:0]             fix_PC,
  output logic                     mispredict,
  output logic [n-1:0]             redirect_PC,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         total_cnt,
  output logic [CNT_W-1:0]         miss_cnt,
  output logic                     err
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [n-1:0] pc;
    logic         pred;
    logic [n-1:0] nex_pc;
  } entry_t;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state, state_nxt;
  entry_t      mem [DEPTH];
  entry_t      head, wr_entry;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop, miss, flush, proto_err;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign pred_ready = (state == RUN) & ~full;
  assign occupancy  = wr_ptr - rd_ptr;

  // Head is read from registered storage, so a same-cycle push can never be popped.
  assign pop   = res_valid & ~empty;
  assign miss  = (head.pred != res_taken) |
                 (res_taken & head.pred & (head.nex_pc != res_target));
  assign flush = pop & miss;
  // A push racing a mispredicted pop belongs to the wrong path: drop it silently.
  assign push  = pred_valid & pred_ready & ~flush;

  assign proto_err = (pred_valid & ~pred_ready) | (res_valid & empty);

  assign wr_entry = '{pc: PC, pred: prediction, nex_pc: nex_PC};

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush) state_nxt = FLUSH;
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fix_valid   <= 1'b0;
      fix_result  <= 1'b0;
      fix_PC      <= '0;
      mispredict  <= 1'b0;
      redirect_PC <= '0;
    end else begin
      fix_valid  <= pop;
      mispredict <= flush;
      if (pop) begin
        fix_result  <= res_taken;
        fix_PC      <= head.pc;
        redirect_PC <= res_taken ? res_target : head.pc + n'(4);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      total_cnt <= '0;
      miss_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      if (pop && total_cnt != {CNT_W{1'b1}})  total_cnt <= total_cnt + 1'b1;
      if (flush && miss_cnt != {CNT_W{1'b1}}) miss_cnt  <= miss_cnt + 1'b1;
      if (proto_err) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: push/resolve/flush/wrap/reset scenarios.
module tb_branch_resolve_queue;
  localparam int n = 32, DEPTH = 4, CNT_W = 16;

  logic clock = 1'b0, reset = 1'b0;
  logic pred_valid = 0, prediction = 0, res_valid = 0, res_taken = 0;
  logic [n-1:0] PC = '0, nex_PC = '0, res_target = '0;
  logic pred_ready, fix_valid, fix_result, mispredict, err;
  logic [n-1:0] fix_PC, redirect_PC;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNT_W-1:0] total_cnt, miss_cnt;

  int passed = 0, total = 0;

  branch_resolve_queue #(.n(n), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .pred_valid(pred_valid), .PC(PC),
    .prediction(prediction), .nex_PC(nex_PC), .res_valid(res_valid),
    .res_taken(res_taken), .res_target(res_target), .pred_ready(pred_ready),
    .fix_valid(fix_valid), .fix_result(fix_result), .fix_PC(fix_PC),
    .mispredict(mispredict), .redirect_PC(redirect_PC), .occupancy(occupancy),
    .total_cnt(total_cnt), .miss_cnt(miss_cnt), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, clock it, and return 1 time unit after the edge.
  task automatic cyc(input logic pv, input logic [n-1:0] pc, input logic pr,
                     input logic [n-1:0] nx, input logic rv, input logic rt,
                     input logic [n-1:0] tg);
    pred_valid = pv; PC = pc; prediction = pr; nex_PC = nx;
    res_valid = rv; res_taken = rt; res_target = tg;
    @(posedge clock); #1;
    pred_valid = 0; res_valid = 0; res_taken = 0;
    PC = '0; nex_PC = '0; res_target = '0; prediction = 0;
  endtask

  task automatic push(input logic [n-1:0] pc, input logic pr, input logic [n-1:0] nx);
    cyc(1, pc, pr, nx, 0, 0, '0);
  endtask

  task automatic resolve(input logic rt, input logic [n-1:0] tg);
    cyc(0, '0, 0, '0, 1, rt, tg);
  endtask

  task automatic idle();
    cyc(0, '0, 0, '0, 0, 0, '0);
  endtask

  initial begin
    // 1: reset state
    #12;
    chk("rst_fix_valid", fix_valid, 0);
    chk("rst_fix_pc", fix_PC, 0);
    chk("rst_redirect", redirect_PC, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_ready", pred_ready, 1);
    chk("rst_total", total_cnt, 0);
    chk("rst_err", err, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    // 2: single correct taken prediction
    push(32'h100, 1, 32'h200);
    chk("t2_occ_push", occupancy, 1);
    chk("t2_no_fix_yet", fix_valid, 0);
    resolve(1, 32'h200);
    chk("t2_fix_valid", fix_valid, 1);
    chk("t2_fix_result", fix_result, 1);
    chk("t2_fix_pc", fix_PC, 32'h100);
    chk("t2_mispredict", mispredict, 0);
    chk("t2_redirect", redirect_PC, 32'h200);
    chk("t2_total", total_cnt, 1);
    chk("t2_occ_pop", occupancy, 0);

    // 3: fill to full, overflow push
    push(32'h10, 1, 32'h110);
    push(32'h20, 1, 32'h120);
    push(32'h30, 1, 32'h130);
    push(32'h40, 1, 32'h140);
    chk("t3_occ_full", occupancy, 4);
    chk("t3_ready_full", pred_ready, 0);
    chk("t3_err_before", err, 0);
    push(32'h50, 1, 32'h150);
    chk("t3_err_overflow", err, 1);
    chk("t3_occ_stays", occupancy, 4);
    resolve(1, 32'h110); chk("t3_order0", fix_PC, 32'h10);
    resolve(1, 32'h120); chk("t3_order1", fix_PC, 32'h20);
    resolve(1, 32'h130); chk("t3_order2", fix_PC, 32'h30);
    resolve(1, 32'h140); chk("t3_order3", fix_PC, 32'h40);
    chk("t3_mispredict", mispredict, 0);
    chk("t3_total", total_cnt, 5);
    chk("t3_occ_drained", occupancy, 0);

    // 4: direction mispredict with younger entries and a simultaneous push
    push(32'h50, 0, 32'h54);
    push(32'h60, 1, 32'h80);
    push(32'h70, 1, 32'h90);
    chk("t4_occ3", occupancy, 3);
    cyc(1, 32'hA0, 1, 32'hA8, 1, 1, 32'h300);
    chk("t4_fix_valid", fix_valid, 1);
    chk("t4_mispredict", mispredict, 1);
    chk("t4_fix_pc", fix_PC, 32'h50);
    chk("t4_redirect", redirect_PC, 32'h300);
    chk("t4_occ_flushed", occupancy, 0);
    chk("t4_flush_ready", pred_ready, 0);
    chk("t4_miss_cnt", miss_cnt, 1);
    chk("t4_total", total_cnt, 6);
    idle();
    chk("t4_ready_back", pred_ready, 1);
    chk("t4_fix_pulse", fix_valid, 0);
    chk("t4_occ_after", occupancy, 0);

    // predicted taken, actually not taken: redirect to fall-through
    push(32'h90, 1, 32'hA0);
    resolve(0, 32'h0);
    chk("nt_mispredict", mispredict, 1);
    chk("nt_result", fix_result, 0);
    chk("nt_redirect", redirect_PC, 32'h94);
    chk("nt_miss", miss_cnt, 2);
    idle();
    // taken both ways but wrong target
    push(32'hB0, 1, 32'hC0);
    resolve(1, 32'hD0);
    chk("tg_mispredict", mispredict, 1);
    chk("tg_redirect", redirect_PC, 32'hD0);
    chk("tg_miss", miss_cnt, 3);
    chk("tg_total", total_cnt, 8);
    idle();
    // predicted not taken, actually not taken: correct
    push(32'hFFFF_FFFC, 0, 32'h0);
    resolve(0, 32'h0);
    chk("nn_mispredict", mispredict, 0);
    chk("nn_redirect_wrap", redirect_PC, 32'h0);
    chk("nn_miss", miss_cnt, 3);

    // 5: steady push+pop at occupancy 2 across pointer wrap
    push(32'h1000, 1, 32'h1040);
    push(32'h1004, 1, 32'h1044);
    chk("t5_occ2", occupancy, 2);
    for (int k = 0; k < 10; k++) begin
      logic [n-1:0] pk, pn;
      pk = 32'h1000 + 4 * k;
      pn = 32'h1000 + 4 * (k + 2);
      cyc(1, pn, 1, pn + 32'h40, 1, 1, pk + 32'h40);
      chk($sformatf("t5_pc%0d", k), fix_PC, pk);
      chk($sformatf("t5_ok%0d", k), {fix_valid, mispredict}, 2'b10);
      chk($sformatf("t5_occ%0d", k), occupancy, 2);
    end
    chk("t5_total", total_cnt, 19);
    chk("t5_miss", miss_cnt, 3);

    // 6a: asynchronous reset mid-queue
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_occ", occupancy, 0);
    chk("t6_rst_total", total_cnt, 0);
    chk("t6_rst_miss", miss_cnt, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_fix_valid", fix_valid, 0);
    chk("t6_rst_fix_pc", fix_PC, 0);
    chk("t6_rst_ready", pred_ready, 1);
    #1 reset = 1'b1;
    @(posedge clock); #1;

    // 6b: resolve with empty queue
    resolve(1, 32'h400);
    chk("t6_err_empty", err, 1);
    chk("t6_total_same", total_cnt, 0);
    chk("t6_no_fix", fix_valid, 0);
    chk("t6_occ", occupancy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
